// File: rtl/i2c_read_master.sv
// I2C read master: START, {addr,R}, reads cmd_len bytes (ACK all but the last, NACK the last), then STOP.
// Each bit cell is four quarters of CLK_DIV cycles. SCL stretching holds Q2. Open-drain outputs are registered.
module i2c_read_master #(
  parameter int CLK_DIV    = 250,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i2c_clk,
  input  logic                  i2c_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [6:0]            cmd_addr,
  input  logic [7:0]            cmd_len,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  done,
  output logic                  nack_err,
  output logic                  busy,
  output logic                  scl_oe,
  input  logic                  scl_in,
  output logic                  sda_oe,
  input  logic                  sda_in
);
  localparam int            QW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] Q_LAST   = QW'(CLK_DIV - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_READ, S_MACK, S_STOP
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [QW-1:0]         r_qcnt, w_qcnt_nxt;
  logic [1:0]            r_quarter, w_quarter_nxt;
  logic [2:0]            r_bit, w_bit_nxt;
  logic [7:0]            r_addr_byte, w_addr_byte_nxt;
  logic [7:0]            r_remain, w_remain_nxt;
  logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_nxt;
  logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data_nxt;
  logic                  r_rx_valid, w_rx_valid_nxt;
  logic                  r_addr_nack, w_addr_nack_nxt;
  logic                  r_nack_err, w_nack_err_nxt;
  logic                  r_scl_oe, w_scl_oe_nxt;
  logic                  r_sda_oe, w_sda_oe_nxt;
  logic                  w_stretchable, w_hold, w_qend, w_cell_end;

  // A slave may stretch SCL only where the master has just released it: Q2 of bit cells and of STOP.
  assign w_stretchable = (r_state == S_ADDR) || (r_state == S_AACK) || (r_state == S_READ) ||
                         (r_state == S_MACK) || (r_state == S_STOP);
  assign w_hold        = w_stretchable && (r_quarter == 2'd2) && (r_qcnt == '0) && !scl_in;
  assign w_qend        = !w_hold && (r_qcnt == Q_LAST);
  assign w_cell_end    = w_qend && (r_quarter == 2'd3);

  always_comb begin
    w_state_nxt     = r_state;
    w_qcnt_nxt      = w_hold ? r_qcnt : (w_qend ? '0 : r_qcnt + QW'(1));
    w_quarter_nxt   = w_qend ? r_quarter + 2'd1 : r_quarter;
    w_bit_nxt       = r_bit;
    w_addr_byte_nxt = r_addr_byte;
    w_remain_nxt    = r_remain;
    w_rx_shift_nxt  = r_rx_shift;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_addr_nack_nxt = r_addr_nack;
    w_nack_err_nxt  = r_nack_err;
    unique case (r_state)
      S_IDLE: begin
        w_qcnt_nxt    = '0;
        w_quarter_nxt = 2'd0;
        if (cmd_valid) begin
          w_state_nxt     = S_START;
          w_addr_byte_nxt = {cmd_addr, 1'b1};
          w_remain_nxt    = cmd_len;
          w_bit_nxt       = 3'd0;
          w_addr_nack_nxt = 1'b0;
        end
      end
      S_START: if (w_cell_end) w_state_nxt = S_ADDR;
      S_ADDR: if (w_cell_end) begin
        w_bit_nxt = r_bit + 3'd1;
        if (r_bit == 3'd7) w_state_nxt = S_AACK;
      end
      S_AACK: if (w_cell_end) begin
        w_addr_nack_nxt = sda_in;
        w_bit_nxt       = 3'd0;
        w_state_nxt     = (sda_in || (r_remain == 8'd0)) ? S_STOP : S_READ;
      end
      S_READ: if (w_cell_end) begin
        w_rx_shift_nxt = {r_rx_shift[DATA_WIDTH-2:0], sda_in};
        w_bit_nxt      = r_bit + 3'd1;
        if (r_bit == BIT_LAST) begin
          w_state_nxt    = S_MACK;
          w_rx_data_nxt  = {r_rx_shift[DATA_WIDTH-2:0], sda_in};
          w_rx_valid_nxt = 1'b1;
        end
      end
      S_MACK: if (w_cell_end) begin
        w_remain_nxt = r_remain - 8'd1;
        w_state_nxt  = (r_remain > 8'd1) ? S_READ : S_STOP;
      end
      S_STOP: if (w_cell_end) begin
        w_state_nxt    = S_IDLE;
        w_nack_err_nxt = r_addr_nack;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus enables are decoded from the next state so the pads come straight from flops.
  always_comb begin
    w_scl_oe_nxt = 1'b0;
    w_sda_oe_nxt = 1'b0;
    unique case (w_state_nxt)
      S_START: begin
        w_scl_oe_nxt = w_quarter_nxt[1];
        w_sda_oe_nxt = 1'b1;
      end
      S_ADDR: begin
        w_scl_oe_nxt = !w_quarter_nxt[1];
        w_sda_oe_nxt = !w_addr_byte_nxt[3'd7 - w_bit_nxt];
      end
      S_AACK, S_READ: w_scl_oe_nxt = !w_quarter_nxt[1];
      S_MACK: begin
        w_scl_oe_nxt = !w_quarter_nxt[1];
        w_sda_oe_nxt = (w_remain_nxt > 8'd1);
      end
      S_STOP: begin
        w_scl_oe_nxt = !w_quarter_nxt[1];
        w_sda_oe_nxt = (w_quarter_nxt != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i2c_clk) begin
    if (i2c_rst) begin
      r_state     <= S_IDLE;
      r_qcnt      <= '0;
      r_quarter   <= 2'd0;
      r_bit       <= 3'd0;
      r_addr_byte <= 8'd0;
      r_remain    <= 8'd0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_addr_nack <= 1'b0;
      r_nack_err  <= 1'b0;
      r_scl_oe    <= 1'b0;
      r_sda_oe    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_qcnt      <= w_qcnt_nxt;
      r_quarter   <= w_quarter_nxt;
      r_bit       <= w_bit_nxt;
      r_addr_byte <= w_addr_byte_nxt;
      r_remain    <= w_remain_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_addr_nack <= w_addr_nack_nxt;
      r_nack_err  <= w_nack_err_nxt;
      r_scl_oe    <= w_scl_oe_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
    end
  end

  // done marks the final STOP cycle; nack_err shows the new flag that same cycle, then holds it.
  assign done      = (r_state == S_STOP) && w_cell_end;
  assign nack_err  = done ? r_addr_nack : r_nack_err;
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign scl_oe    = r_scl_oe;
  assign sda_oe    = r_sda_oe;
endmodule
